// File: rtl/cfg_ws_pkg.sv
// cfg_ws_pkg: shared wait-state FSM encoding, default region decode constants
// and region index names for the FSB wait-state generator.
package cfg_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_READY = 2'd2,
    ST_HOLD  = 2'd3
  } ws_state_e;

  localparam int RGN_RAM = 0;
  localparam int RGN_ROM = 1;
  localparam int RGN_IO  = 2;

  // Regions packed 2..0, one nibble per region, compared against A_FSB[23:20]
  localparam logic [11:0] DEF_REGION_VAL  = {4'h4, 4'h0, 4'h0};
  localparam logic [11:0] DEF_REGION_MASK = {4'hF, 4'hF, 4'hC};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_ws_decode.sv
// cfg_ws_decode: combinational priority decoder from A_FSB[23:20] to region
// index; lowest matching region wins, the last region is the fall-through.
module cfg_ws_decode
  import cfg_ws_pkg::*;
#(
  parameter int                   NREGION     = 3,
  parameter logic [NREGION*4-1:0] REGION_VAL  = DEF_REGION_VAL,
  parameter logic [NREGION*4-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter int                   RW          = idx_width(NREGION)
) (
  input  logic [3:0]    i_addr,
  output logic [RW-1:0] o_region
);

  logic [NREGION-1:0] w_match;

  // Per-region masked compare
  always_comb begin
    w_match = '0;
    for (int r = 0; r < NREGION; r++) begin
      w_match[r] = ((i_addr & REGION_MASK[r*4 +: 4]) ==
                    (REGION_VAL[r*4 +: 4] & REGION_MASK[r*4 +: 4]));
    end
  end

  // Priority select; walking downwards lets the lowest hit overwrite higher ones
  always_comb begin
    o_region = RW'(NREGION - 1);
    for (int r = NREGION - 2; r >= 0; r--) begin
      o_region = w_match[r] ? RW'(r) : o_region;
    end
  end

endmodule

// File: rtl/cfg_ws.sv
// cfg_ws: per-region programmable wait-state generator for FSB cycles; stretches
// each accepted cycle by the region's count and then pulses Ready once.
module cfg_ws
  import cfg_ws_pkg::*;
#(
  parameter int                   NREGION     = 3,
  parameter int                   WSW         = 4,
  parameter logic [NREGION*4-1:0] REGION_VAL  = DEF_REGION_VAL,
  parameter logic [NREGION*4-1:0] REGION_MASK = DEF_REGION_MASK
) (
  input  logic                           FCLK,
  input  logic                           Reset,
  input  logic [3:0]                     A_FSB,
  input  logic                           nAS_FSB,
  input  logic [NREGION*WSW-1:0]         StrapWS,
  input  logic                           CfgWr,
  input  logic [idx_width(NREGION)-1:0]  CfgRegion,
  input  logic [WSW-1:0]                 CfgData,
  output logic [NREGION-1:0]             WS,
  output logic                           Ready,
  output logic                           Busy
);

  localparam int RW = idx_width(NREGION);

  logic [WSW-1:0]     r_cfg [NREGION];
  ws_state_e          r_state;
  logic [WSW-1:0]     r_cnt;
  logic [NREGION-1:0] r_ws;
  logic               r_ready;
  logic               r_busy;

  logic [RW-1:0]      w_region;
  logic [WSW-1:0]     w_count;

  cfg_ws_decode #(
    .NREGION     (NREGION),
    .REGION_VAL  (REGION_VAL),
    .REGION_MASK (REGION_MASK),
    .RW          (RW)
  ) u_decode (
    .i_addr   (A_FSB),
    .o_region (w_region)
  );

  assign w_count = r_cfg[w_region];

  // Config registers: strap load during reset, out-of-range region writes drop out
  always_ff @(posedge FCLK) begin
    for (int r = 0; r < NREGION; r++) begin
      if (Reset) begin
        r_cfg[r] <= StrapWS[r*WSW +: WSW];
      end else if (CfgWr && (int'(CfgRegion) == r)) begin
        r_cfg[r] <= CfgData;
      end
    end
  end

  // Cycle FSM; the count is captured at acceptance so later config writes
  // never disturb a cycle already in flight
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ws    <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (!nAS_FSB) begin
            r_busy <= 1'b1;
            if (w_count == '0) begin
              r_state <= ST_READY;
              r_ready <= 1'b1;
              r_ws    <= '0;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_COUNT;
              r_cnt   <= w_count - WSW'(1);
              r_ws    <= NREGION'(1) << w_region;
            end
          end else begin
            r_busy <= 1'b0;
            r_ws   <= '0;
          end
        end
        ST_COUNT: begin
          if (nAS_FSB) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ws    <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_READY;
            r_ws    <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - WSW'(1);
          end
        end
        ST_READY: begin
          r_state <= ST_HOLD;
          r_ready <= 1'b0;
        end
        ST_HOLD: begin
          if (nAS_FSB) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_ws    <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign WS    = r_ws;
  assign Ready = r_ready;
  assign Busy  = r_busy;

endmodule

// File: tb/tb_cfg_ws.sv
// tb_cfg_ws: directed self-checking bench for cfg_ws in its default build
// (RAM = A 0..3, IO = everything else; ROM is shadowed by RAM at A=0).
module tb_cfg_ws;

  logic        FCLK = 1'b0;
  logic        Reset;
  logic [3:0]  A_FSB;
  logic        nAS_FSB;
  logic [11:0] StrapWS;
  logic        CfgWr;
  logic [1:0]  CfgRegion;
  logic [3:0]  CfgData;
  logic [2:0]  WS;
  logic        Ready;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;

  cfg_ws dut (
    .FCLK      (FCLK),
    .Reset     (Reset),
    .A_FSB     (A_FSB),
    .nAS_FSB   (nAS_FSB),
    .StrapWS   (StrapWS),
    .CfgWr     (CfgWr),
    .CfgRegion (CfgRegion),
    .CfgData   (CfgData),
    .WS        (WS),
    .Ready     (Ready),
    .Busy      (Busy)
  );

  always #5 FCLK = ~FCLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] rgn, input logic [3:0] data);
    CfgWr = 1'b1; CfgRegion = rgn; CfgData = data;
    tick();
    CfgWr = 1'b0;
  endtask

  // Full bus cycle: n wait states on the one-hot ws_exp, one Ready, then release
  task automatic bus_cycle(input string tag, input logic [3:0] addr, input int n,
                           input logic [2:0] ws_exp);
    A_FSB = addr; nAS_FSB = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      check({tag, "_ws"}, {5'd0, WS}, {5'd0, ws_exp});
      check({tag, "_nordy"}, {7'd0, Ready}, 8'd0);
      check({tag, "_busy"}, {7'd0, Busy}, 8'd1);
      tick();
    end
    check({tag, "_rdy"}, {7'd0, Ready}, 8'd1);
    check({tag, "_ws_off"}, {5'd0, WS}, 8'd0);
    tick();
    check({tag, "_rdy_once"}, {7'd0, Ready}, 8'd0);
    check({tag, "_hold_busy"}, {7'd0, Busy}, 8'd1);
    nAS_FSB = 1'b1;
    tick();
    check({tag, "_idle_busy"}, {7'd0, Busy}, 8'd0);
  endtask

  initial begin
    Reset = 1'b1; nAS_FSB = 1'b1; A_FSB = 4'h0;
    StrapWS = {4'd2, 4'd0, 4'd3};
    CfgWr = 1'b0; CfgRegion = 2'd0; CfgData = 4'd0;
    repeat (3) tick();
    check("rst_ws", {5'd0, WS}, 8'd0);
    check("rst_ready", {7'd0, Ready}, 8'd0);
    check("rst_busy", {7'd0, Busy}, 8'd0);
    Reset = 1'b0;
    tick();

    // Strap timings: RAM 3, IO 2; A=0 hits RAM ahead of ROM
    bus_cycle("ram1", 4'h1, 3, 3'b001);
    bus_cycle("io4", 4'h4, 2, 3'b100);
    bus_cycle("ram0", 4'h0, 3, 3'b001);

    // Config write during COUNT leaves the in-flight count at 2
    A_FSB = 4'hE; nAS_FSB = 1'b0;
    tick();
    check("iowr_ws1", {5'd0, WS}, 8'h04);
    CfgWr = 1'b1; CfgRegion = 2'd2; CfgData = 4'd5;
    tick();
    CfgWr = 1'b0;
    check("iowr_ws2", {5'd0, WS}, 8'h04);
    check("iowr_nordy", {7'd0, Ready}, 8'd0);
    tick();
    check("iowr_rdy", {7'd0, Ready}, 8'd1);
    tick();
    nAS_FSB = 1'b1;
    tick();
    bus_cycle("io5", 4'hE, 5, 3'b100);

    // Out-of-range region write is ignored
    cfg_write(2'd3, 4'd7);
    bus_cycle("oor_ram", 4'h2, 3, 3'b001);
    bus_cycle("oor_io", 4'h8, 5, 3'b100);

    // Zero count: Ready right after acceptance
    cfg_write(2'd0, 4'd0);
    bus_cycle("zero", 4'h3, 0, 3'b000);

    // Strobe held low after Ready: no re-acceptance until a high cycle
    A_FSB = 4'h1; nAS_FSB = 1'b0;
    tick();
    check("held_rdy", {7'd0, Ready}, 8'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("held_nordy", {7'd0, Ready}, 8'd0);
      check("held_busy", {7'd0, Busy}, 8'd1);
    end
    nAS_FSB = 1'b1;
    tick();
    check("held_rel", {7'd0, Busy}, 8'd0);
    nAS_FSB = 1'b0;
    tick();
    check("held_again", {7'd0, Ready}, 8'd1);
    tick();
    nAS_FSB = 1'b1;
    tick();

    // Abort mid-COUNT
    A_FSB = 4'hE; nAS_FSB = 1'b0;
    tick();
    tick();
    check("abort_ws", {5'd0, WS}, 8'h04);
    nAS_FSB = 1'b1;
    tick();
    check("abort_ws0", {5'd0, WS}, 8'd0);
    check("abort_busy", {7'd0, Busy}, 8'd0);
    for (int k = 0; k < 6; k++) begin
      check("abort_nordy", {7'd0, Ready}, 8'd0);
      tick();
    end

    // Reset mid-COUNT: outputs drop, counts return to straps
    A_FSB = 4'hE; nAS_FSB = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("mrst_ws", {5'd0, WS}, 8'd0);
    check("mrst_ready", {7'd0, Ready}, 8'd0);
    check("mrst_busy", {7'd0, Busy}, 8'd0);
    Reset = 1'b0; nAS_FSB = 1'b1;
    tick();
    bus_cycle("mrst_ram", 4'h1, 3, 3'b001);
    bus_cycle("mrst_io", 4'hE, 2, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
